// File: rtl/cache_refill_unit_if.sv
// Memory-side bus of the cache refill unit: one request channel plus a read-response channel.
interface cache_refill_unit_if #(
    parameter int ADDR_SIZE = 32
);
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ADDR_SIZE-1:0] mem_req_addr;
    logic                 mem_req_write;
    logic [31:0]          mem_req_wdata;
    logic                 mem_resp_valid;
    logic [31:0]          mem_resp_data;

    // The refill unit issues requests and consumes responses.
    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_write,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    // Main memory accepts requests and returns read words.
    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_write,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/cache_refill_unit.sv
// Data-cache miss handler: refills a whole block on a read miss and
// forwards every store to memory (write-through, no write-allocate),
// stalling the core until each operation has completed.
module cache_refill_unit #(
    parameter int ADDR_SIZE   = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic                 req_write,
    input  logic [31:0]          req_wdata,
    input  logic                 cache_hit,
    output logic                 stall,
    output logic                 fill_enable,
    output logic [ADDR_SIZE-1:0] fill_addr,
    output logic [31:0]          fill_data,
    output logic                 fill_last,
    cache_refill_unit_if.master  mem_bus
);

    localparam int WordOffsetSize = $clog2(BLOCK_WORDS);
    // A single-word block still needs a one-bit counter to index.
    localparam int CountSize = (WordOffsetSize > 0) ? WordOffsetSize : 1;
    localparam logic [CountSize-1:0] LastCount = CountSize'(BLOCK_WORDS - 1);
    localparam logic [ADDR_SIZE-1:0] BlockMask = ADDR_SIZE'(BLOCK_WORDS * 4 - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE_REQ,
        READ_REQ,
        FILL,
        RESUME
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CountSize-1:0] count;
    logic                 start_write;
    logic                 start_read;
    logic                 resp_accept;
    logic                 last_word;

    // Decode the events that drive both the FSM and the datapath registers.
    always_comb begin
        start_write = (state == IDLE) && req_valid && req_write;
        start_read  = (state == IDLE) && req_valid && !req_write && !cache_hit;
        resp_accept = (state == FILL) && mem_bus.mem_resp_valid;
        last_word   = resp_accept && (count == LastCount);
    end

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_write) begin
                    next_state = WRITE_REQ;
                end else if (start_read) begin
                    next_state = READ_REQ;
                end
            end
            WRITE_REQ: begin
                if (mem_bus.mem_req_ready) begin
                    next_state = RESUME;
                end
            end
            READ_REQ: begin
                if (mem_bus.mem_req_ready) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (last_word) begin
                    next_state = RESUME;
                end
            end
            RESUME: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered memory request fields and word counter; the request address doubles as the fill base.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_bus.mem_req_valid <= 1'b0;
            mem_bus.mem_req_write <= 1'b0;
            mem_bus.mem_req_addr  <= '0;
            mem_bus.mem_req_wdata <= '0;
            count                 <= '0;
        end else begin
            if (start_write) begin
                mem_bus.mem_req_valid <= 1'b1;
                mem_bus.mem_req_write <= 1'b1;
                mem_bus.mem_req_addr  <= req_addr;
                mem_bus.mem_req_wdata <= req_wdata;
            end else if (start_read) begin
                mem_bus.mem_req_valid <= 1'b1;
                mem_bus.mem_req_write <= 1'b0;
                mem_bus.mem_req_addr  <= req_addr & ~BlockMask;
                count                 <= '0;
            end else if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
                mem_bus.mem_req_valid <= 1'b0;
            end
            if (resp_accept && !last_word) begin
                count <= count + CountSize'(1);
            end
        end
    end

    // Core stall and cache fill outputs, combinational so fills line up with memory responses.
    always_comb begin
        stall = ((state != IDLE) && (state != RESUME)) ||
                ((state == IDLE) && req_valid && (req_write || !cache_hit));
        fill_enable = resp_accept;
        fill_last   = last_word;
        fill_addr   = '0;
        fill_data   = '0;
        if (resp_accept) begin
            fill_addr = mem_bus.mem_req_addr + ADDR_SIZE'({count, 2'b00});
            fill_data = mem_bus.mem_resp_data;
        end
    end

endmodule

// File: doc/cache_refill_unit.md
# cache_refill_unit

Miss handler between the data cache and main memory. It watches each core access and the cache `hit` flag. On a read miss it fetches the whole block from memory and writes it word by word into the cache. Every store is forwarded to memory (write-through, no write-allocate), and the core is stalled until each operation completes.

## Interface
Parameters:
- `ADDR_SIZE`, 32, byte-address width.
- `BLOCK_WORDS`, 4, 32-bit words per cache block; power of two, ≥1.
- Derived: `WordOffsetSize = $clog2(BLOCK_WORDS)`; block base is `{addr[ADDR_SIZE-1:WordOffsetSize+2], 0}`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core access present.
- `req_addr` in ADDR_SIZE: core byte address.
- `req_write` in 1: 1 = store, 0 = load.
- `req_wdata` in 32: store data.
- `cache_hit` in 1: cache lookup hit for `req_addr`.
- `stall` out 1: core must hold its request.
- `fill_enable` out 1: write `fill_data` into the cache at `fill_addr`.
- `fill_addr` out ADDR_SIZE: word-aligned fill address.
- `fill_data` out 32: refill word.
- `fill_last` out 1: final word of the block; the cache populates the way and updates LRU.
- `mem_req_valid` out 1: memory request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_SIZE: block base for reads, `req_addr` for writes.
- `mem_req_write` out 1: request type.
- `mem_req_wdata` out 32: store data.
- `mem_resp_valid` in 1: read word returned.
- `mem_resp_data` in 32: returned word; words return in order, starting at the block base.

## Operation
- FSM states: IDLE, WRITE_REQ, READ_REQ, FILL, RESUME.
- IDLE:
  - `req_valid & req_write`: latch addr/data, go to WRITE_REQ.
  - `req_valid & !req_write & !cache_hit`: latch block base, clear word counter, go to READ_REQ.
  - Otherwise stay in IDLE.
- WRITE_REQ: drive `mem_req_valid=1`, `mem_req_write=1`, latched addr/wdata. On `mem_req_ready`, go to RESUME.
- READ_REQ: drive `mem_req_valid=1`, `mem_req_write=0`, `mem_req_addr`=block base. On `mem_req_ready`, go to FILL.
- FILL: on each `mem_resp_valid` cycle:
  - `fill_enable=1`, `fill_data=mem_resp_data`, `fill_addr=base + 4*count`; counter increments.
  - On `count == BLOCK_WORDS-1`: also `fill_last=1`, go to RESUME.
  - No response in a cycle: hold state and counter, `fill_enable=0`.
- RESUME: `stall=0` for exactly one cycle, then IDLE. During this cycle a refilled read hits, and a store hit is written by the cache itself.
- `stall = (state != IDLE && state != RESUME) || (state == IDLE && req_valid && (req_write || !cache_hit))`. The IDLE term is combinational.
- `mem_resp_valid` outside FILL is ignored; it produces no fill.
- Counter width is `max(1, WordOffsetSize)` and is never allowed to wrap: the FILL exit happens at BLOCK_WORDS-1.
- `mem_req_*` are driven from registers; request fields stay stable while `mem_req_valid & !mem_req_ready`.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `mem_req_valid`, `fill_enable`, `fill_last` = 0.
  - `mem_req_addr`, `mem_req_wdata`, `fill_addr`, `fill_data` = 0.
  - `stall` follows its equation with state = IDLE.
- `rst` during any state: next cycle is IDLE and the in-flight memory transaction is abandoned. Memory shares `rst`.
- Read miss latency, with memory ready and responses back-to-back from the cycle after acceptance:
  - Cycle 0: miss detected in IDLE.
  - Cycle 1: READ_REQ, accepted.
  - Cycles 2..BLOCK_WORDS+1: FILL.
  - Cycle BLOCK_WORDS+2: RESUME.
  - Stall lasts BLOCK_WORDS+2 cycles.
- Store latency with `mem_req_ready=1`: IDLE → WRITE_REQ → RESUME; stall is 2 cycles.
- Hit load in IDLE: `stall=0`, zero added latency.
- `fill_enable` and `fill_last` are combinational from `mem_resp_valid` in FILL: one-cycle pulses aligned with the response.
- A new request in RESUME is not examined; it is evaluated in IDLE on the following cycle.

## Test plan
- Reset, then hit load (`req_valid=1`, `cache_hit=1`): `stall=0`, `mem_req_valid=0` throughout.
- Read miss at 0x0000_0048, BLOCK_WORDS=4, memory always ready:
  - `mem_req_addr=0x40`, `mem_req_write=0`.
  - Responses 0xA0..0xA3 produce fills at 0x40, 0x44, 0x48, 0x4C.
  - `fill_last` only with 0xA3; `stall` high 6 cycles, then low 1 cycle.
- Store to 0x100, data 0xDEADBEEF, `mem_req_ready` low for 3 cycles:
  - Request fields held stable.
  - Accepted on cycle 4; `stall` released the following cycle; no fill pulses.
- Read miss with gaps: `mem_resp_valid` pattern 1,0,0,1,1,0,1 → exactly 4 fills, addresses consecutive, counter frozen during gaps.
- `rst` asserted in FILL after 2 words → IDLE next cycle, all outputs at reset values; later `mem_resp_valid` pulses produce no fill.
- Spurious `mem_resp_valid` in IDLE/WRITE_REQ → no `fill_enable`, state unchanged.
